// File: rtl/awgn_output_mult.sv
// -----------------------------------------------------------------------------
// awgn_output_mult
//
// Final Box-Muller stage. Multiplies the radial term f = sqrt(-2 ln u0) by the
// cos/sin outputs of the Sin/Cos unit. Every accepted input produces two
// independent noise samples, x0 = f*g0 and x1 = f*g1. The block is a three
// stage pipeline with valid/ready handshakes on both sides. Products are
// rounded half-up and saturated into Q4.11, and two status counters are kept.
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous, active-low reset
//   in_valid    f_in, g0_in and g1_in are valid this cycle
//   in_ready    the pipeline can take an input this cycle
//   f_in        radial term, unsigned UQ4.13
//   g0_in       cos term, two's complement Q1.14
//   g1_in       sin term, two's complement Q1.14
//   out_valid   x0_out/x1_out hold a valid sample pair
//   out_ready   the consumer takes the pair this cycle
//   x0_out      f*g0, two's complement Q4.11
//   x1_out      f*g1, two's complement Q4.11
//   sample_cnt  pairs delivered (out_valid & out_ready), wraps around
//   sat_cnt     individual samples clipped, sticks at all-ones
// -----------------------------------------------------------------------------
module awgn_output_mult #(
  parameter int F_W    = 17,
  parameter int G_W    = 16,
  parameter int X_W    = 16,
  parameter int CNT_W  = 32,
  parameter int SAT_W  = 16,
  parameter int F_FRAC = 13,
  parameter int G_FRAC = 14,
  parameter int X_FRAC = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F_W-1:0]   f_in,
  input  logic [G_W-1:0]   g0_in,
  input  logic [G_W-1:0]   g1_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   x0_out,
  output logic [X_W-1:0]   x1_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [SAT_W-1:0] sat_cnt
);

  // Width of the sign-extended multiplier operands. f gets a zero sign bit
  // so it can enter a signed multiply, and g is widened to the same size.
  // This assumes F_W >= G_W, which holds for the Box-Muller datapath.
  localparam int E_W   = F_W + 1;

  // Signed product width. The magnitude of f*g never exceeds 2^(F_W+G_W-1),
  // so F_W+G_W bits hold every product exactly.
  localparam int P_W   = F_W + G_W;

  // Number of fractional bits dropped when going from the product format
  // down to the output format.
  localparam int SHIFT = F_FRAC + G_FRAC - X_FRAC;

  // Half an output LSB expressed in product units, used for rounding.
  localparam logic [P_W:0] HALF =
    {{(P_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

  // Output limits, widened to the rounding width so the comparison is done
  // on the full rounded value rather than on a truncated copy.
  localparam logic signed [P_W:0] R_MAX =
    {{(P_W - X_W + 2){1'b0}}, {(X_W - 1){1'b1}}};
  localparam logic signed [P_W:0] R_MIN =
    {{(P_W - X_W + 2){1'b1}}, {(X_W - 1){1'b0}}};

  localparam logic [X_W-1:0] X_MAX = {1'b0, {(X_W - 1){1'b1}}};
  localparam logic [X_W-1:0] X_MIN = {1'b1, {(X_W - 1){1'b0}}};

  logic                  adv;

  logic                  s1_valid;
  logic [F_W-1:0]        s1_f;
  logic signed [E_W-1:0] s1_g0;
  logic signed [E_W-1:0] s1_g1;

  logic                  s2_valid;
  logic signed [P_W-1:0] s2_p0;
  logic signed [P_W-1:0] s2_p1;

  logic signed [P_W-1:0] prod0;
  logic signed [P_W-1:0] prod1;

  logic [X_W-1:0]        rs0_x;
  logic [X_W-1:0]        rs1_x;
  logic                  rs0_clip;
  logic                  rs1_clip;
  logic [SAT_W:0]        sat_sum;
  logic [SAT_W-1:0]      sat_next;

  // Round half-up toward +inf, then clamp into the output range. The
  // result is packed as {clipped, value}. The arithmetic shift of the
  // biased product is a floor division, which is what turns the +half
  // bias into round-half-up for negative values as well.
  function automatic logic [X_W:0] round_sat(input logic signed [P_W-1:0] p);
    logic signed [P_W:0] biased;
    logic signed [P_W:0] r;
    biased = $signed({p[P_W-1], p}) + $signed(HALF);
    r      = biased >>> SHIFT;
    if (r > R_MAX) begin
      return {1'b1, X_MAX};
    end else if (r < R_MIN) begin
      return {1'b1, X_MIN};
    end else begin
      return {1'b0, r[X_W-1:0]};
    end
  endfunction

  // The whole pipeline moves forward whenever the output register is empty
  // or is being drained this cycle. A single advance signal for all stages
  // keeps the stages in lock-step, so a stall freezes everything at once.
  // Input acceptance is additionally blocked while reset is asserted.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & reset_n;

  // Stage 1 captures f and sign-extends the cos/sin terms to the multiplier
  // operand width. Data is only captured with a valid input, so idle or
  // undefined input values never enter the pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_g0    <= '0;
      s1_g1    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_f  <= f_in;
        s1_g0 <= {{(E_W - G_W){g0_in[G_W-1]}}, g0_in};
        s1_g1 <= {{(E_W - G_W){g1_in[G_W-1]}}, g1_in};
      end
    end
  end

  // Signed multiplies. The products are computed directly at P_W bits;
  // both operands are signed, so they are sign-extended to that width
  // before multiplying and the truncated result is exact.
  assign prod0 = $signed({1'b0, s1_f}) * s1_g0;
  assign prod1 = $signed({1'b0, s1_f}) * s1_g1;

  // Stage 2 holds the full-precision products for the rounding stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_p0    <= '0;
      s2_p1    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p0 <= prod0;
        s2_p1 <= prod1;
      end
    end
  end

  // Round/saturate both products and work out the next clip count. The
  // clip count saturates at all-ones: the sum is formed one bit wider and
  // a carry out of the top bit means the counter would have wrapped.
  always_comb begin
    rs0_x    = '0;
    rs1_x    = '0;
    rs0_clip = 1'b0;
    rs1_clip = 1'b0;
    {rs0_clip, rs0_x} = round_sat(s2_p0);
    {rs1_clip, rs1_x} = round_sat(s2_p1);
    sat_sum  = {1'b0, sat_cnt}
             + {{(SAT_W - 1){1'b0}}, ({1'b0, rs0_clip} + {1'b0, rs1_clip})};
    sat_next = sat_sum[SAT_W] ? {SAT_W{1'b1}} : sat_sum[SAT_W-1:0];
  end

  // Stage 3 is the output register. Clipped samples are counted at the
  // moment a pair enters this stage, so every pair is counted exactly once
  // regardless of how long it later sits here under back-pressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      x0_out    <= '0;
      x1_out    <= '0;
      sat_cnt   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        x0_out  <= rs0_x;
        x1_out  <= rs1_x;
        sat_cnt <= sat_next;
      end
    end
  end

  // Delivered-pair counter. It is free-running and simply wraps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_awgn_output_mult.sv
// -----------------------------------------------------------------------------
// tb_awgn_output_mult
//
// Testbench for awgn_output_mult. A table of hand-computed vectors checks the
// arithmetic and the pipeline latency; a reference model (plain integer
// arithmetic on f*g with floor-based rounding) follows every accepted input
// and checks every delivered pair in order, while random traffic, a stall
// window, a mid-flight reset and a long clipping run exercise the handshake
// and counter corner cases.
// -----------------------------------------------------------------------------
module tb_awgn_output_mult;

  localparam int NUM_VEC = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] f_in;
  logic [15:0] g0_in;
  logic [15:0] g1_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x0_out;
  logic [15:0] x1_out;
  logic [31:0] sample_cnt;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] f;
    logic [15:0] g0;
    logic [15:0] g1;
    logic [15:0] x0;
    logic [15:0] x1;
    int          clips;
  } vec_t;

  vec_t vecs [NUM_VEC];

  logic [31:0] expQ[$];
  int          modelSat = 0;
  logic        stallHeld = 1'b0;
  logic [15:0] heldX0;
  logic [15:0] heldX1;
  logic [16:0] r0;
  logic [16:0] r1;
  logic [31:0] e;

  always #5 clk = ~clk;

  awgn_output_mult dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .f_in       (f_in),
    .g0_in      (g0_in),
    .g1_in      (g1_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .x0_out     (x0_out),
    .x1_out     (x1_out),
    .sample_cnt (sample_cnt),
    .sat_cnt    (sat_cnt)
  );

  // Reference for one sample: exact product, add half an output LSB, floor
  // divide by 2^16, then clamp. Returns {clipped, value}.
  function automatic logic [16:0] refSample(input logic [16:0] f, input logic [15:0] g);
    longint fl, gl, p, n, r;
    fl = longint'(f);
    gl = longint'($signed(g));
    p  = fl * gl;
    n  = p + 32768;
    if (n >= 0) r = n / 65536;
    else        r = -((-n + 65535) / 65536);
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    f_in     = 17'($urandom);
    g0_in    = 16'($urandom);
    g1_in    = 16'($urandom);
  endtask

  // Presents one input and holds it until the DUT takes it. Returns just
  // after the accepting clock edge with the input side idle again.
  task automatic applyStimulus(input logic [16:0] f, input logic [15:0] g0, input logic [15:0] g1);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    f_in     = f;
    g0_in    = g0;
    g1_in    = g1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      stepCycle();
    end
    if (!acc) checkOutput("accept timeout", 0, 1);
    idleInputs();
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((expQ.size() != 0 || out_valid) && k < 20) begin
      stepCycle();
      k++;
    end
    if (expQ.size() != 0 || out_valid) checkOutput("drain timeout pending", expQ.size(), 0);
  endtask

  // Scoreboard, evaluated on the falling edge where every signal is stable
  // and describes what the next rising edge will do.
  always @(negedge clk) begin
    if (!reset_n) begin
      expQ.delete();
      modelSat  = 0;
      stallHeld = 1'b0;
    end else begin
      if (stallHeld && out_valid) begin
        checkOutput("stall x0 stable", x0_out, heldX0);
        checkOutput("stall x1 stable", x1_out, heldX1);
      end
      stallHeld = 1'b0;
      if (out_valid && !out_ready) begin
        checkOutput("stall in_ready", in_ready, 0);
        stallHeld = 1'b1;
        heldX0    = x0_out;
        heldX1    = x1_out;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected pair: got x0=0x%0h x1=0x%0h, required no output", x0_out, x1_out);
        end else begin
          e = expQ.pop_front();
          checkOutput("model x0", x0_out, e[31:16]);
          checkOutput("model x1", x1_out, e[15:0]);
        end
      end
      if (in_valid && in_ready) begin
        r0 = refSample(f_in, g0_in);
        r1 = refSample(f_in, g1_in);
        expQ.push_back({r0[15:0], r1[15:0]});
        modelSat = modelSat + int'(r0[16]) + int'(r1[16]);
        if (modelSat > 65535) modelSat = 65535;
      end
    end
  end

  initial begin
    int cumSat;
    int idx;
    int fed;
    int expSamples;
    logic acc;
    logic [16:0] rf;
    logic [15:0] rg0, rg1;

    vecs[0] = '{17'h02000, 16'h4000, 16'h0000, 16'h0800, 16'h0000, 0};
    vecs[1] = '{17'h04000, 16'hE000, 16'h2000, 16'hF800, 16'h0800, 0};
    vecs[2] = '{17'h1FFFF, 16'h4000, 16'hC000, 16'h7FFF, 16'h8000, 1};
    vecs[3] = '{17'h00002, 16'h4000, 16'hC000, 16'h0001, 16'h0000, 0};
    vecs[4] = '{17'h1FFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 2};
    vecs[5] = '{17'h00001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 0};
    vecs[6] = '{17'h02000, 16'h2000, 16'hE000, 16'h0400, 16'hFC00, 0};

    reset_n   = 1'b0;
    out_ready = 1'b0;
    idleInputs();
    repeat (3) stepCycle();
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset x0", x0_out, 0);
    checkOutput("reset x1", x1_out, 0);
    checkOutput("reset sample_cnt", sample_cnt, 0);
    checkOutput("reset sat_cnt", sat_cnt, 0);
    reset_n = 1'b1;
    stepCycle();

    // Table vectors, one at a time, with an exact latency check.
    $display("[TB] table vectors");
    cumSat = 0;
    for (int i = 0; i < NUM_VEC; i++) begin
      out_ready = 1'b1;
      applyStimulus(vecs[i].f, vecs[i].g0, vecs[i].g1);
      checkOutput($sformatf("vec%0d out_valid c1", i), out_valid, 0);
      stepCycle();
      checkOutput($sformatf("vec%0d out_valid c2", i), out_valid, 0);
      stepCycle();
      cumSat += vecs[i].clips;
      checkOutput($sformatf("vec%0d out_valid c3", i), out_valid, 1);
      checkOutput($sformatf("vec%0d x0", i), x0_out, vecs[i].x0);
      checkOutput($sformatf("vec%0d x1", i), x1_out, vecs[i].x1);
      checkOutput($sformatf("vec%0d sat_cnt", i), sat_cnt, cumSat);
      stepCycle();
      checkOutput($sformatf("vec%0d sample_cnt", i), sample_cnt, i + 1);
      checkOutput($sformatf("vec%0d bubble", i), out_valid, 0);
    end

    // Ten back-to-back inputs with the consumer stalling on cycles 4..7.
    $display("[TB] stream with stall");
    idx = 0;
    for (int c = 1; c <= 60 && idx < 10; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (c == 1 || acc) begin
        f_in  = 17'($urandom);
        g0_in = 16'($urandom);
        g1_in = 16'($urandom);
      end
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      stepCycle();
      if (acc) idx++;
    end
    idleInputs();
    drain();
    checkOutput("stream accepted", idx, 10);
    expSamples = NUM_VEC + 10;
    checkOutput("stream sample_cnt", sample_cnt, expSamples);

    // Random traffic on both sides, including full-scale operands.
    $display("[TB] random traffic");
    fed = 0;
    acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (acc) begin
        rf  = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'($urandom);
        rg0 = ($urandom_range(0, 3) == 0) ? 16'h8000  : 16'($urandom);
        rg1 = 16'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      f_in  = in_valid ? rf  : 17'($urandom);
      g0_in = in_valid ? rg0 : 16'($urandom);
      g1_in = in_valid ? rg1 : 16'($urandom);
      @(negedge clk);
      acc = !in_valid || in_ready;
      if (in_valid && in_ready) fed++;
      stepCycle();
    end
    idleInputs();
    drain();
    expSamples += fed;
    checkOutput("random sample_cnt", sample_cnt, expSamples);
    checkOutput("random sat_cnt", sat_cnt, modelSat);

    // Reset with three pairs in flight, then re-feed the first vector.
    $display("[TB] reset in flight");
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1'b1;
      f_in     = 17'($urandom);
      g0_in    = 16'($urandom);
      g1_in    = 16'($urandom);
      @(negedge clk);
      acc = in_ready;
      stepCycle();
      if (acc) idx++;
    end
    idleInputs();
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("in-reset in_ready", in_ready, 0);
    stepCycle();
    reset_n = 1'b1;
    checkOutput("post-reset out_valid", out_valid, 0);
    checkOutput("post-reset sample_cnt", sample_cnt, 0);
    checkOutput("post-reset sat_cnt", sat_cnt, 0);
    stepCycle();
    checkOutput("post-reset flushed", out_valid, 0);
    applyStimulus(vecs[0].f, vecs[0].g0, vecs[0].g1);
    stepCycle();
    stepCycle();
    checkOutput("refeed out_valid", out_valid, 1);
    checkOutput("refeed x0", x0_out, 16'h0800);
    checkOutput("refeed x1", x1_out, 16'h0000);
    stepCycle();
    checkOutput("refeed sample_cnt", sample_cnt, 1);

    // Drive sat_cnt up to 0xFFFE with pairs that clip in both samples,
    // then confirm it stops at 0xFFFF.
    $display("[TB] sat_cnt ceiling");
    idx = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    f_in      = vecs[4].f;
    g0_in     = vecs[4].g0;
    g1_in     = vecs[4].g1;
    for (int c = 0; c < 40000 && idx < 32767; c++) begin
      @(negedge clk);
      acc = in_ready;
      stepCycle();
      if (acc) idx++;
    end
    idleInputs();
    drain();
    checkOutput("sat run accepted", idx, 32767);
    checkOutput("sat_cnt near full", sat_cnt, 16'hFFFE);
    applyStimulus(vecs[4].f, vecs[4].g0, vecs[4].g1);
    drain();
    checkOutput("sat_cnt ceiling", sat_cnt, 16'hFFFF);
    applyStimulus(vecs[4].f, vecs[4].g0, vecs[4].g1);
    drain();
    checkOutput("sat_cnt sticks", sat_cnt, 16'hFFFF);
    checkOutput("sat run sample_cnt", sample_cnt, 1 + 32767 + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
